// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory req/ready bus, aligns store lanes,
// extends load data, flags misaligned / timed-out accesses and fills the MEM_WB register.
module mem_access_stage #(
  parameter int          DMEM_TIMEOUT = 16,
  parameter logic [31:0] RESET_PC     = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic [31:0] EX_MEM_inst,
  input  logic [31:0] EX_MEM_pc,
  input  logic [31:0] EX_MEM_alu,
  input  logic [31:0] EX_MEM_rs2,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_is_load,
  input  logic        EX_MEM_is_store,
  input  logic        EX_MEM_is_jal,
  input  logic        EX_MEM_is_jalr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MEM_WB_inst,
  output logic [31:0] MEM_WB_pc,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_data,
  output logic        MEM_WB_wen,
  output logic        MEM_stall,
  output logic [1:0]  MEM_exc
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(DMEM_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tcnt;
  logic [31:0] hold_rdata;

  logic [2:0]  f3;
  logic [1:0]  a;
  logic        mem_op, misaligned, timeout_hit, done_now, wb_load, wb_wen;
  logic [31:0] rsrc, shifted, ld_ext, wb_data, st_wdata;
  logic [3:0]  st_be;

  assign f3     = EX_MEM_inst[14:12];
  assign a      = EX_MEM_alu[1:0];
  assign mem_op = EX_MEM_is_load | EX_MEM_is_store;

  // Only memory ops can be misaligned; ALU ops share the f3 encoding space.
  assign misaligned = mem_op & (((f3[1:0] == 2'b01) & a[0]) |
                                ((f3[1:0] == 2'b10) & (a != 2'b00)));

  assign timeout_hit = (state == BUSY) & ~dmem_ready & ~HLT & (tcnt == TO_LAST);
  assign done_now    = ((state == BUSY) & dmem_ready & ~HLT) | ((state == DONE) & ~HLT);
  assign MEM_stall   = mem_op & ~(done_now | misaligned | timeout_hit);

  assign wb_load = ~HLT & (((state == IDLE) & ~(mem_op & ~misaligned)) |
                           ((state == BUSY) & dmem_ready) |
                           timeout_hit |
                           (state == DONE));

  // A halted completion parks its data in hold_rdata until DONE drains it.
  assign rsrc    = (state == DONE) ? hold_rdata : dmem_rdata;
  assign shifted = rsrc >> {a, 3'b000};

  always_comb begin
    ld_ext = shifted;
    case (f3)
      3'b000:  ld_ext = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = EX_MEM_rs2;
    case (f3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << a;
        st_wdata = {4{EX_MEM_rs2[7:0]}};
      end
      2'b01: begin
        st_be    = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{EX_MEM_rs2[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = EX_MEM_rs2;
      end
    endcase
  end

  assign wb_data = (EX_MEM_is_jal | EX_MEM_is_jalr) ? EX_MEM_pc + 32'd4 :
                   EX_MEM_is_load                   ? ld_ext : EX_MEM_alu;

  assign wb_wen = (EX_MEM_inst != 32'h0) & (EX_MEM_rd != 5'd0) & ~EX_MEM_is_store &
                  (EX_MEM_inst[6:0] != 7'b1100011) & ~misaligned & ~timeout_hit;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state      <= IDLE;
      tcnt       <= 8'd0;
      hold_rdata <= 32'h0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'h0;
      MEM_exc    <= 2'b00;
    end else begin
      MEM_exc <= 2'b00;
      case (state)
        IDLE: if (!HLT) begin
          if (mem_op & ~misaligned) begin
            dmem_req   <= 1'b1;
            dmem_we    <= EX_MEM_is_store;
            dmem_addr  <= {EX_MEM_alu[31:2], 2'b00};
            dmem_wdata <= st_wdata;
            dmem_be    <= EX_MEM_is_store ? st_be : 4'b1111;
            tcnt       <= 8'd0;
            state      <= BUSY;
          end else if (misaligned) begin
            MEM_exc <= 2'b01;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (HLT) begin
              hold_rdata <= dmem_rdata;
              state      <= DONE;
            end else begin
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            MEM_exc  <= 2'b10;
            state    <= IDLE;
          end else if (tcnt != TO_LAST) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DONE: if (!HLT) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      MEM_WB_inst <= 32'h0;
      MEM_WB_pc   <= RESET_PC;
      MEM_WB_rd   <= 5'd0;
      MEM_WB_data <= 32'h0;
      MEM_WB_wen  <= 1'b0;
    end else if (wb_load) begin
      MEM_WB_inst <= EX_MEM_inst;
      MEM_WB_pc   <= EX_MEM_pc;
      MEM_WB_rd   <= EX_MEM_rd;
      MEM_WB_data <= wb_data;
      MEM_WB_wen  <= wb_wen;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, halt, timeout, reset.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RES, HLT;
  logic [31:0] EX_MEM_inst, EX_MEM_pc, EX_MEM_alu, EX_MEM_rs2;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_is_load, EX_MEM_is_store, EX_MEM_is_jal, EX_MEM_is_jalr;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] MEM_WB_inst, MEM_WB_pc, MEM_WB_data;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_wen, MEM_stall;
  logic [1:0]  MEM_exc;

  int total  = 0;
  int passed = 0;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_JAL  = 7'b1101111, OP_BR    = 7'b1100011;

  mem_access_stage #(.DMEM_TIMEOUT(16), .RESET_PC(32'h8000_0000)) dut (
    .CLK(CLK), .RES(RES), .HLT(HLT),
    .EX_MEM_inst(EX_MEM_inst), .EX_MEM_pc(EX_MEM_pc), .EX_MEM_alu(EX_MEM_alu),
    .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_is_load(EX_MEM_is_load), .EX_MEM_is_store(EX_MEM_is_store),
    .EX_MEM_is_jal(EX_MEM_is_jal), .EX_MEM_is_jalr(EX_MEM_is_jalr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .MEM_WB_inst(MEM_WB_inst), .MEM_WB_pc(MEM_WB_pc), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_data(MEM_WB_data), .MEM_WB_wen(MEM_WB_wen),
    .MEM_stall(MEM_stall), .MEM_exc(MEM_exc)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, op};
  endfunction

  task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2);
    EX_MEM_inst     = (op == 7'h0) ? 32'h0 : mk(op, f3, rd);
    EX_MEM_rd       = rd;
    EX_MEM_pc       = pc;
    EX_MEM_alu      = alu;
    EX_MEM_rs2      = rs2;
    EX_MEM_is_load  = (op == OP_LOAD);
    EX_MEM_is_store = (op == OP_STORE);
    EX_MEM_is_jal   = (op == OP_JAL);
    EX_MEM_is_jalr  = 1'b0;
  endtask

  task automatic bubble();
    set_ex(7'h0, 3'h0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic next();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RES = 1'b1; HLT = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    bubble();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++; if (MEM_WB_pc !== 32'h8000_0000) $display("FAIL reset_pc: got %h want 80000000", MEM_WB_pc); else passed++;
    total++; if ({MEM_WB_inst, MEM_WB_data, MEM_WB_rd, MEM_WB_wen} !== 70'h0)
      $display("FAIL reset_wb: inst %h data %h rd %0d wen %b want all 0", MEM_WB_inst, MEM_WB_data, MEM_WB_rd, MEM_WB_wen); else passed++;
    total++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, MEM_exc} !== 72'h0)
      $display("FAIL reset_bus: req %b we %b be %b addr %h wdata %h exc %b want 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, MEM_exc); else passed++;
    RES = 1'b0;
    next();
  endtask

  task automatic test_load_zero_wait();
    set_ex(OP_LOAD, 3'b010, 5'd5, 32'h10, 32'h100, 32'h0);
    #1;
    total++; if (MEM_stall !== 1'b1 || dmem_req !== 1'b0) $display("FAIL lw_idle: stall %b req %b want 1 0", MEM_stall, dmem_req); else passed++;
    next();
    total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 1'b0 || dmem_be !== 4'hF)
      $display("FAIL lw_bus: req %b addr %h we %b be %b want 1 100 0 1111", dmem_req, dmem_addr, dmem_we, dmem_be); else passed++;
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (MEM_stall !== 1'b0) $display("FAIL lw_ready_stall: got %b want 0", MEM_stall); else passed++;
    next();
    dmem_ready = 1'b0; bubble();
    total++; if (MEM_WB_data !== 32'hDEAD_BEEF || MEM_WB_wen !== 1'b1 || MEM_WB_rd !== 5'd5 || dmem_req !== 1'b0)
      $display("FAIL lw_wb: data %h wen %b rd %0d req %b want deadbeef 1 5 0", MEM_WB_data, MEM_WB_wen, MEM_WB_rd, dmem_req); else passed++;
    next();
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] alus [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
    for (int i = 0; i < 4; i++) begin
      set_ex(OP_LOAD, f3s[i], 5'd6, 32'h20, alus[i], 32'h0);
      next();
      dmem_ready = 1'b1; dmem_rdata = 32'h80FF_0000;
      next();
      dmem_ready = 1'b0; bubble();
      total++; if (MEM_WB_data !== exps[i] || MEM_WB_wen !== 1'b1)
        $display("FAIL load_ext%0d: data %h wen %b want %h 1", i, MEM_WB_data, MEM_WB_wen, exps[i]); else passed++;
    end
    next();
  endtask

  task automatic test_store_lanes();
    set_ex(OP_STORE, 3'b001, 5'd7, 32'h30, 32'h202, 32'h1234_ABCD);
    next();
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h200)
      $display("FAIL sh_bus: req %b we %b be %b wdata %h addr %h want 1 1 1100 abcdabcd 200", dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr); else passed++;
    dmem_ready = 1'b1;
    next();
    dmem_ready = 1'b0;
    total++; if (MEM_WB_wen !== 1'b0 || dmem_req !== 1'b0) $display("FAIL sh_wb: wen %b req %b want 0 0", MEM_WB_wen, dmem_req); else passed++;
    set_ex(OP_STORE, 3'b000, 5'd0, 32'h34, 32'h101, 32'h0000_0077);
    next();
    total++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h7777_7777 || dmem_addr !== 32'h100)
      $display("FAIL sb_bus: be %b wdata %h addr %h want 0010 77777777 100", dmem_be, dmem_wdata, dmem_addr); else passed++;
    dmem_ready = 1'b1;
    next();
    dmem_ready = 1'b0; bubble();
    next();
  endtask

  task automatic test_misaligned();
    set_ex(OP_LOAD, 3'b010, 5'd8, 32'h40, 32'h101, 32'h0);
    #1;
    total++; if (MEM_stall !== 1'b0) $display("FAIL mis_stall: got %b want 0", MEM_stall); else passed++;
    next();
    total++; if (MEM_exc !== 2'b01 || dmem_req !== 1'b0 || MEM_WB_wen !== 1'b0 || MEM_WB_inst !== mk(OP_LOAD, 3'b010, 5'd8))
      $display("FAIL mis_exc: exc %b req %b wen %b inst %h want 01 0 0 %h", MEM_exc, dmem_req, MEM_WB_wen, MEM_WB_inst, mk(OP_LOAD, 3'b010, 5'd8)); else passed++;
    bubble();
    next();
    total++; if (MEM_exc !== 2'b00 || dmem_req !== 1'b0) $display("FAIL mis_clear: exc %b req %b want 00 0", MEM_exc, dmem_req); else passed++;
  endtask

  task automatic test_nonmem();
    set_ex(OP_ALU, 3'b000, 5'd4, 32'h50, 32'h1234, 32'h0);
    #1;
    total++; if (MEM_stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", MEM_stall); else passed++;
    next();
    total++; if (MEM_WB_data !== 32'h1234 || MEM_WB_wen !== 1'b1 || MEM_WB_pc !== 32'h50)
      $display("FAIL alu_wb: data %h wen %b pc %h want 1234 1 50", MEM_WB_data, MEM_WB_wen, MEM_WB_pc); else passed++;
    set_ex(OP_JAL, 3'b000, 5'd1, 32'h8000_0010, 32'h999, 32'h0);
    next();
    total++; if (MEM_WB_data !== 32'h8000_0014 || MEM_WB_wen !== 1'b1)
      $display("FAIL jal_wb: data %h wen %b want 80000014 1", MEM_WB_data, MEM_WB_wen); else passed++;
    set_ex(OP_BR, 3'b000, 5'd9, 32'h60, 32'h1, 32'h0);
    next();
    total++; if (MEM_WB_wen !== 1'b0 || MEM_WB_pc !== 32'h60) $display("FAIL br_wb: wen %b pc %h want 0 60", MEM_WB_wen, MEM_WB_pc); else passed++;
    bubble();
    next();
  endtask

  task automatic test_halt_busy();
    set_ex(OP_LOAD, 3'b010, 5'd3, 32'h70, 32'h40, 32'h0);
    next();
    HLT = 1'b1;
    next();
    dmem_ready = 1'b1; dmem_rdata = 32'h55;
    next();
    dmem_ready = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    total++; if (dmem_req !== 1'b0 || MEM_stall !== 1'b1 || MEM_WB_inst !== 32'h0)
      $display("FAIL halt_done: req %b stall %b wb_inst %h want 0 1 0", dmem_req, MEM_stall, MEM_WB_inst); else passed++;
    next();
    total++; if (MEM_WB_inst !== 32'h0 || MEM_WB_data === 32'h55) $display("FAIL halt_frozen: wb_inst %h data %h want 0 (not 55)", MEM_WB_inst, MEM_WB_data); else passed++;
    HLT = 1'b0;
    #1;
    total++; if (MEM_stall !== 1'b0) $display("FAIL halt_release_stall: got %b want 0", MEM_stall); else passed++;
    next();
    bubble();
    total++; if (MEM_WB_data !== 32'h55 || MEM_WB_wen !== 1'b1 || MEM_WB_rd !== 5'd3)
      $display("FAIL halt_wb: data %h wen %b rd %0d want 55 1 3", MEM_WB_data, MEM_WB_wen, MEM_WB_rd); else passed++;
    next();
  endtask

  task automatic test_timeout();
    int bad = 0;
    set_ex(OP_STORE, 3'b010, 5'd0, 32'h90, 32'h300, 32'hCAFE_F00D);
    next();
    for (int i = 0; i < 15; i++) begin
      if (dmem_req !== 1'b1 || MEM_exc !== 2'b00) bad++;
      next();
    end
    total++; if (bad != 0 || dmem_req !== 1'b1) $display("FAIL to_hold: early drop count %0d req %b want 0 1", bad, dmem_req); else passed++;
    total++; if (MEM_stall !== 1'b0) $display("FAIL to_stall: got %b want 0 on 16th busy cycle", MEM_stall); else passed++;
    next();
    bubble();
    total++; if (MEM_exc !== 2'b10 || dmem_req !== 1'b0 || MEM_WB_wen !== 1'b0 || MEM_WB_pc !== 32'h90)
      $display("FAIL to_abort: exc %b req %b wen %b pc %h want 10 0 0 90", MEM_exc, dmem_req, MEM_WB_wen, MEM_WB_pc); else passed++;
    next();
    total++; if (MEM_exc !== 2'b00) $display("FAIL to_pulse: exc %b want 00", MEM_exc); else passed++;
  endtask

  task automatic test_reset_midbusy();
    set_ex(OP_LOAD, 3'b010, 5'd11, 32'hA0, 32'h10, 32'h0);
    next();
    total++; if (dmem_req !== 1'b1 || MEM_WB_pc !== 32'h0) $display("FAIL rst_pre: req %b wb_pc %h want 1 0", dmem_req, MEM_WB_pc); else passed++;
    #2 RES = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b0 || MEM_WB_pc !== 32'h8000_0000 || MEM_WB_inst !== 32'h0 || MEM_WB_data !== 32'h0 || MEM_WB_wen !== 1'b0)
      $display("FAIL rst_mid: req %b pc %h inst %h data %h wen %b want 0 80000000 0 0 0", dmem_req, MEM_WB_pc, MEM_WB_inst, MEM_WB_data, MEM_WB_wen); else passed++;
    bubble();
    #2 RES = 1'b0;
    dmem_ready = 1'b1;
    next();
    dmem_ready = 1'b0;
    total++; if (dmem_req !== 1'b0 || MEM_WB_wen !== 1'b0) $display("FAIL rst_discard: req %b wen %b want 0 0", dmem_req, MEM_WB_wen); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_load_extend();
    test_store_lanes();
    test_misaligned();
    test_nonmem();
    test_halt_busy();
    test_timeout();
    test_reset_midbusy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
